mdu_unit: RTL and testbench



---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mdu_calc.sv | 41 ++++
 rtl/mdu_unit.sv | 86 ++++++++
 tb/tb_mdu_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
// MFHI/MFLO map to NONE here because the HI/LO read mux lives in the pipeline.
package mdu_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_issue_op(input mdu_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_div_op(input mdu_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit {hi,lo} result for mult/multu/div/divu.
// Signed division works on magnitudes so 0x80000000 / -1 cannot overflow.
module mdu_calc
  import mdu_pkg::*;
(
  input  mdu_op_t     op,
  input  logic [31:0] v1,
  input  logic [31:0] v2,
  output logic [63:0] result,
  output logic        div_zero
);

  logic        sgn;
  logic [31:0] a_mag, b_mag, b_safe, uq, ur, q, r;
  logic [63:0] prod_s, prod_u;

  // Product, quotient/remainder and result select.
  always_comb begin
    result   = 64'd0;
    div_zero = (v2 == 32'd0);
    sgn      = (op == DIV);
    a_mag    = (sgn && v1[31]) ? (32'd0 - v1) : v1;
    b_mag    = (sgn && v2[31]) ? (32'd0 - v2) : v2;
    b_safe   = div_zero ? 32'd1 : b_mag;
    uq       = a_mag / b_safe;
    ur       = a_mag % b_safe;
    // quotient truncates toward zero, remainder follows the dividend's sign
    q        = (sgn && (v1[31] ^ v2[31])) ? (32'd0 - uq) : uq;
    r        = (sgn && v1[31]) ? (32'd0 - ur) : ur;
    prod_s   = {{32{v1[31]}}, v1} * {{32{v2[31]}}, v2};
    prod_u   = {32'd0, v1} * {32'd0, v2};
    case (op)
      MULT:     result = prod_s;
      MULTU:    result = prod_u;
      DIV,
      DIVU:     result = {r, q};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle MDU: latches the result at issue, holds busy for a fixed
// latency, then commits to HI/LO. MTHI/MTLO write directly while idle.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  mdu_op_t     op,
  input  logic [31:0] v1,
  input  logic [31:0] v2,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_t  state;
  logic [CW-1:0] cnt;
  logic [63:0] pend;
  logic        pend_dz;
  logic [63:0] calc_res;
  logic        calc_dz;

  mdu_calc u_calc (
    .op       (op),
    .v1       (v1),
    .v2       (v2),
    .result   (calc_res),
    .div_zero (calc_dz)
  );

  // Issue/run FSM with latency counter, pending result and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      pend    <= 64'd0;
      pend_dz <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && is_issue_op(op)) begin
            pend    <= calc_res;
            pend_dz <= calc_dz && is_div_op(op);
            cnt     <= is_div_op(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            busy    <= 1'b1;
            state   <= RUN;
          end else if (op == MTHI) begin
            hi <= v1;
          end else if (op == MTLO) begin
            lo <= v1;
          end
        end
        RUN: begin
          // the counter value seen at an edge is the number of busy cycles left
          if (cnt == CW'(1)) begin
            if (!pend_dz) begin
              hi <= pend[63:32];
              lo <= pend[31:0];
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: driver queues expected HI/LO and busy length,
// a monitor checks them when busy falls; directed cases plus random ops.
module tb_mdu_unit;
  import mdu_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          ncyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  mdu_op_t     op;
  logic [31:0] v1, v2;
  logic        busy;
  logic [31:0] hi, lo;

  exp_t        sb[$];
  logic [31:0] m_hi, m_lo;
  int          n_checks = 0;
  int          n_fail   = 0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .v1    (v1),
    .v2    (v2),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: new {hi,lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input mdu_op_t o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint          sa, sb2, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (o)
      MULT:  begin sp = sa * sb2; return sp; end
      MULTU: begin up = ua * ub; return up; end
      DIV: begin
        if (b == 32'd0) return cur;
        sq = sa / sb2;
        sr = sa % sb2;
        return {sr[31:0], sq[31:0]};
      end
      DIVU: begin
        if (b == 32'd0) return cur;
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return cur;
    endcase
  endfunction

  function automatic int lat(input mdu_op_t o);
    return (o == DIV || o == DIVU) ? 10 : 5;
  endfunction

  // Called right after a negedge: drive the issue and queue the expectation.
  task automatic drive_issue(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] r;
    r     = model(o, a, b, {m_hi, m_lo});
    m_hi  = r[63:32];
    m_lo  = r[31:0];
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.ncyc = lat(o);
    sb.push_back(e);
    start = 1'b1; op = o; v1 = a; v2 = b;
    @(negedge clk);
    start = 1'b0; op = NONE;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 40; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (busy) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: busy still %b after 40 cycles, required 0", busy);
    end
  endtask

  task automatic issue(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
    drive_issue(o, a, b);
    wait_idle();
  endtask

  task automatic mt(input mdu_op_t o, input logic [31:0] val, input logic s);
    start = s; op = o; v1 = val; v2 = $urandom;
    if (o == MTHI) m_hi = val; else m_lo = val;
    @(negedge clk);
    start = 1'b0; op = NONE;
    chk("mt_busy", {63'd0, busy}, 64'd0);
    chk("mt_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  // Monitor: checks hi/lo and busy length each time busy falls.
  initial begin
    int   bcnt;
    logic prev_busy;
    exp_t e;
    bcnt = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt = 0;
        prev_busy = 1'b0;
      end else begin
        if (busy) begin
          bcnt++;
        end else if (prev_busy) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL sb_unexpected: commit with hi=%h lo=%h, required none", hi, lo);
          end else begin
            e = sb.pop_front();
            chk("commit_hi", {32'd0, hi}, {32'd0, e.hi});
            chk("commit_lo", {32'd0, lo}, {32'd0, e.lo});
            chk("busy_len", 64'(bcnt), 64'(e.ncyc));
          end
          bcnt = 0;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    mdu_op_t     o;
    rst_n = 1'b0; start = 1'b0; op = NONE; v1 = 32'd0; v2 = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    #1;
    chk("reset_state", {31'd0, busy, hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(MULT, 32'hFFFFFFFE, 32'd3);
    chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    issue(MULTU, 32'hFFFFFFFF, 32'd2);
    chk("multu", {hi, lo}, 64'h00000001_FFFFFFFE);
    issue(DIV, 32'hFFFFFFF9, 32'd2);
    chk("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(DIVU, 32'hFFFFFFF9, 32'd2);
    chk("divu", {hi, lo}, 64'h00000001_7FFFFFFC);

    mt(MTHI, 32'h12345678, 1'b0);
    mt(MTLO, 32'h9ABCDEF0, 1'b1);
    issue(DIVU, 32'h55555555, 32'd0);
    chk("div_zero", {hi, lo}, 64'h12345678_9ABCDEF0);
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf", {hi, lo}, 64'h00000000_80000000);

    // MULT with a stray DIV issue and MTLO while running
    drive_issue(MULT, 32'd1000, 32'hFFFFFFF6);
    start = 1'b1; op = DIV; v1 = 32'd77; v2 = 32'd5;
    @(negedge clk);
    start = 1'b0; op = MTLO; v1 = 32'hDEADBEEF;
    @(negedge clk);
    op = NONE;
    wait_idle();
    chk("run_ignore", {hi, lo}, 64'hFFFFFFFF_FFFFD8F0);

    // Asynchronous reset in the middle of a divide
    drive_issue(DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    m_hi = 32'd0; m_lo = 32'd0;
    #1;
    chk("async_reset", {31'd0, busy, hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {63'd0, busy}, 64'd0);
    issue(MULT, 32'd6, 32'd7);
    chk("post_reset_mult", {hi, lo}, 64'd42);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 :
          ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      case ($urandom_range(0, 5))
        0: o = MULT;
        1: o = MULTU;
        2: o = DIV;
        3: o = DIVU;
        4: o = MTHI;
        default: o = MTLO;
      endcase
      if (o == MTHI || o == MTLO) mt(o, a, 1'($urandom_range(0, 1)));
      else issue(o, a, b);
    end

    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
